uart_tx_arbiter: RTL

// - Shares the single uart_core TX FIFO write port between NUM_REQ byte-stream requesters.
// - Arbitration is round-robin at packet granularity. A granted requester keeps the port

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arbiter_if
// Description : Requester-side and uart_core-side signals of the UART TX
//               arbiter, bundled so the arbiter and its users share one port.
//               The master modport is the requester/uart_core side; the slave
//               modport is the arbiter itself.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_wr_en;
  logic [7:0]           tx_wr_data;
  logic                 tx_full;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_wr_en, tx_wr_data, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_wr_en, tx_wr_data, busy, grant_id
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing the uart_core TX
//               FIFO write port between NUM_REQ byte-stream requesters. A
//               granted requester owns the port until its last byte is taken.
// Options     : UART_ARB_CKSUM_EN - append an 8-bit XOR checksum after each
//               packet's last byte.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  bus
);

`ifdef UART_ARB_CKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_CKSUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    w_pick;
  logic               w_any;
  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_data;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_wr_en;
  logic [7:0]         w_wr_data;
  logic               w_pkt_done;
`ifdef UART_ARB_CKSUM_EN
  logic [7:0]         r_cksum;
`endif

  // First valid requester after ptr, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    ptr);
    int   idx;
    logic found;
    f_rr_pick = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        found     = 1'b1;
        f_rr_pick = ID_W'(idx);
      end
    end
  endfunction

  assign w_any       = |bus.req_valid;
  assign w_pick      = f_rr_pick(bus.req_valid, r_rr_ptr);
  assign w_own_valid = bus.req_valid[r_grant_id];
  assign w_own_last  = bus.req_last[r_grant_id];
  assign w_own_data  = bus.req_data[{r_grant_id, 3'b000} +: 8];

  // Next-state and handshake decode; data moves only in XFER/CKSUM.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_wr_en     = 1'b0;
    w_wr_data   = w_own_data;
    w_pkt_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        w_ready[r_grant_id] = ~bus.tx_full;
        w_wr_en             = w_own_valid & ~bus.tx_full;
        if (w_wr_en && w_own_last) begin
          w_pkt_done = 1'b1;
`ifdef UART_ARB_CKSUM_EN
          w_state_nxt = S_CKSUM;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef UART_ARB_CKSUM_EN
      S_CKSUM: begin
        w_wr_en   = ~bus.tx_full;
        w_wr_data = r_cksum;
        if (!bus.tx_full) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; a reset mid-packet abandons the packet.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant capture in IDLE; pointer advances only when a packet completes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_grant_id <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) r_grant_id <= w_pick;
      if (w_pkt_done)                 r_rr_ptr   <= r_grant_id;
    end
  end

`ifdef UART_ARB_CKSUM_EN
  // Running XOR of accepted payload bytes, cleared when a packet is granted.
  always_ff @(posedge clk) begin
    if (!reset_n)                          r_cksum <= 8'h00;
    else if (r_state == S_IDLE && w_any)   r_cksum <= 8'h00;
    else if (r_state == S_XFER && w_wr_en) r_cksum <= r_cksum ^ w_own_data;
  end
`endif

  // Handshake outputs are forced low while reset is held.
  assign bus.req_ready  = reset_n ? w_ready : '0;
  assign bus.tx_wr_en   = reset_n & w_wr_en;
  assign bus.tx_wr_data = w_wr_data;
  assign bus.busy       = reset_n & (r_state != S_IDLE);
  assign bus.grant_id   = r_grant_id;

endmodule

`default_nettype wire
